// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - multi-cycle logical shift controller for an external 4-bit + 1-bit shift-stage chain
//
// Ports:
//   CLK, RST_N            rising-edge clock, asynchronous active-low reset
//   START, DIR, SHAMT     request (taken only when BUSY=0), direction (0=left, 1=right), amount
//   DATA_IN               operand, sampled with START
//   STAGE_Q / STAGE_D     working register to the stage chain / chain result back
//   L4/N4/R4_SHIFT, _NOT  one-hot select (and complements) for the 4-bit stage
//   L1/N1/R1_SHIFT, _NOT  one-hot select (and complements) for the 1-bit stage
//   BUSY, DONE, RESULT    status, one-cycle completion pulse, final value

module shift_sequencer #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               START,
   input  logic               DIR,
   input  logic [SHAMT_W-1:0] SHAMT,
   input  logic [WIDTH-1:0]   DATA_IN,
   output logic [WIDTH-1:0]   STAGE_Q,
   input  logic [WIDTH-1:0]   STAGE_D,
   output logic               L4_SHIFT,
   output logic               N4_SHIFT,
   output logic               R4_SHIFT,
   output logic               L4_NOT,
   output logic               N4_NOT,
   output logic               R4_NOT,
   output logic               L1_SHIFT,
   output logic               N1_SHIFT,
   output logic               R1_SHIFT,
   output logic               L1_NOT,
   output logic               N1_NOT,
   output logic               R1_NOT,
   output logic               BUSY,
   output logic               DONE,
   output logic [WIDTH-1:0]   RESULT
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]         state_q,  state_d;
   logic [WIDTH-1:0]   reg_q,    reg_d;
   logic [SHAMT_W-1:0] rem_q,    rem_d;
   logic               dir_q,    dir_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               in_shift;
   logic               act4;
   logic               act1;
   logic [SHAMT_W-1:0] rem_next;

   // Stage activity is decoded from registered state only, so the selects
   // never see a combinational path from the request inputs.
   assign in_shift = (state_q == ST_SHIFT);
   assign act4     = in_shift && (rem_q >= SHAMT_W'(4));
   assign act1     = in_shift && (rem_q[1:0] != 2'b00);

   // {act4, 0, act1} is the step size 4*act4 + act1 as a 3-bit number.
   assign rem_next = rem_q - SHAMT_W'({act4, 1'b0, act1});

   always_comb begin
      state_d  = state_q;
      reg_d    = reg_q;
      rem_d    = rem_q;
      dir_d    = dir_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE: begin
            if (START) begin
               reg_d = DATA_IN;
               dir_d = DIR;
               rem_d = SHAMT;
               if (SHAMT == '0) begin
                  state_d  = ST_DONE;
                  result_d = DATA_IN;
               end else begin
                  state_d  = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            reg_d = STAGE_D;
            rem_d = rem_next;
            if (rem_next == '0) begin
               result_d = STAGE_D;
               state_d  = ST_DONE;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         reg_q    <= '0;
         rem_q    <= '0;
         dir_q    <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         reg_q    <= reg_d;
         rem_q    <= rem_d;
         dir_q    <= dir_d;
         result_q <= result_d;
      end
   end

   assign L4_SHIFT = act4 & ~dir_q;
   assign R4_SHIFT = act4 &  dir_q;
   assign N4_SHIFT = ~act4;
   assign L1_SHIFT = act1 & ~dir_q;
   assign R1_SHIFT = act1 &  dir_q;
   assign N1_SHIFT = ~act1;

   assign L4_NOT = ~L4_SHIFT;
   assign N4_NOT = ~N4_SHIFT;
   assign R4_NOT = ~R4_SHIFT;
   assign L1_NOT = ~L1_SHIFT;
   assign N1_NOT = ~N1_SHIFT;
   assign R1_NOT = ~R1_SHIFT;

   assign STAGE_Q = reg_q;
   assign RESULT  = result_q;
   assign BUSY    = (state_q == ST_SHIFT) || (state_q == ST_DONE);
   assign DONE    = (state_q == ST_DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - directed self-checking bench for shift_sequencer

module tb_shift_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        dir = 1'b0;
   logic [4:0]  shamt = 5'd0;
   logic [31:0] data_in = 32'd0;
   logic [31:0] stage_q;
   logic [31:0] stage_d;
   logic        l4, n4, r4, l4n, n4n, r4n;
   logic        l1, n1, r1, l1n, n1n, r1n;
   logic        busy, done;
   logic [31:0] result;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
      .CLK(clk), .RST_N(rst_n), .START(start), .DIR(dir), .SHAMT(shamt),
      .DATA_IN(data_in), .STAGE_Q(stage_q), .STAGE_D(stage_d),
      .L4_SHIFT(l4), .N4_SHIFT(n4), .R4_SHIFT(r4),
      .L4_NOT(l4n), .N4_NOT(n4n), .R4_NOT(r4n),
      .L1_SHIFT(l1), .N1_SHIFT(n1), .R1_SHIFT(r1),
      .L1_NOT(l1n), .N1_NOT(n1n), .R1_NOT(r1n),
      .BUSY(busy), .DONE(done), .RESULT(result)
   );

   // Behavioural stage chain: 4-bit stage then 1-bit stage, logical, zero fill.
   logic [31:0] s4;
   always_comb begin
      s4 = stage_q;
      if (l4)      s4 = stage_q << 4;
      else if (r4) s4 = stage_q >> 4;
      stage_d = s4;
      if (l1)      stage_d = s4 << 1;
      else if (r1) stage_d = s4 >> 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_sels(input string tag, input logic [2:0] exp4, input logic [2:0] exp1);
      check({tag, " sel4"}, {29'd0, l4, n4, r4}, {29'd0, exp4});
      check({tag, " sel1"}, {29'd0, l1, n1, r1}, {29'd0, exp1});
   endtask

   // Structural select rules, checked in every sampled cycle.
   task automatic check_rules();
      check("onehot4", {31'd0, $onehot({l4, n4, r4})}, 32'd1);
      check("onehot1", {31'd0, $onehot({l1, n1, r1})}, 32'd1);
      check("compl4", {29'd0, l4n, n4n, r4n}, {29'd0, ~{l4, n4, r4}});
      check("compl1", {29'd0, l1n, n1n, r1n}, {29'd0, ~{l1, n1, r1}});
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      check_rules();
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check_rules();
      check("rst busy", {31'd0, busy}, 32'd0);
      check("rst done", {31'd0, done}, 32'd0);
      check("rst result", result, 32'd0);
      check("rst stage_q", stage_q, 32'd0);
      check_sels("rst", 3'b010, 3'b010);
      tick();
      rst_n = 1'b1;
      tick();

      // Left shift 1 by 7: L4+L1, then N4+L1 twice
      start = 1'b1; dir = 1'b0; shamt = 5'd7; data_in = 32'h0000_0001;
      tick();
      start = 1'b0;
      check("l7 busy", {31'd0, busy}, 32'd1);
      check_sels("l7 c1", 3'b100, 3'b100);
      tick();
      check_sels("l7 c2", 3'b010, 3'b100);
      check("l7 c2 stage_q", stage_q, 32'h0000_0020);
      tick();
      check_sels("l7 c3", 3'b010, 3'b100);
      check("l7 c3 done", {31'd0, done}, 32'd0);
      tick();
      check("l7 done", {31'd0, done}, 32'd1);
      check("l7 result", result, 32'h0000_0080);
      check("l7 stage_q hold", stage_q, 32'h0000_0080);
      check_sels("l7 done", 3'b010, 3'b010);
      tick();
      check("l7 done pulse", {31'd0, done}, 32'd0);
      check("l7 idle busy", {31'd0, busy}, 32'd0);
      check("l7 result hold", result, 32'h0000_0080);

      // Right shift 0x80000000 by 31: R4 for 7 cycles, R1 for the first 3
      start = 1'b1; dir = 1'b1; shamt = 5'd31; data_in = 32'h8000_0000;
      for (int i = 1; i <= 7; i++) begin
         tick();
         start = 1'b0;
         check_sels($sformatf("r31 c%0d", i), 3'b001, (i <= 3) ? 3'b001 : 3'b010);
         check($sformatf("r31 c%0d done", i), {31'd0, done}, 32'd0);
      end
      tick();
      check("r31 done", {31'd0, done}, 32'd1);
      check("r31 result", result, 32'h0000_0001);
      tick();

      // Zero shift: DONE next cycle, no stage ever active
      start = 1'b1; dir = 1'b0; shamt = 5'd0; data_in = 32'hDEAD_BEEF;
      tick();
      start = 1'b0;
      check("z done", {31'd0, done}, 32'd1);
      check("z busy", {31'd0, busy}, 32'd1);
      check("z result", result, 32'hDEAD_BEEF);
      check_sels("z", 3'b010, 3'b010);
      tick();
      check("z busy after", {31'd0, busy}, 32'd0);
      check("z done after", {31'd0, done}, 32'd0);
      check_sels("z after", 3'b010, 3'b010);

      // START while busy is ignored
      start = 1'b1; dir = 1'b0; shamt = 5'd12; data_in = 32'h0000_000F;
      tick();
      check_sels("ign c1", 3'b100, 3'b010);
      dir = 1'b1; shamt = 5'd4; data_in = 32'hFFFF_FFFF;
      tick();
      check_sels("ign c2", 3'b100, 3'b010);
      check("ign c2 stage_q", stage_q, 32'h0000_00F0);
      tick();
      check_sels("ign c3", 3'b100, 3'b010);
      tick();
      check("ign done", {31'd0, done}, 32'd1);
      check("ign result", result, 32'h0000_F000);
      start = 1'b0;
      tick();
      check("ign idle busy", {31'd0, busy}, 32'd0);
      check("ign result hold", result, 32'h0000_F000);

      // Reset in the 2nd SHIFT cycle of a 20-bit shift
      start = 1'b1; dir = 1'b0; shamt = 5'd20; data_in = 32'h0000_0001;
      tick();
      start = 1'b0;
      tick();
      check("mid busy pre", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("mid busy", {31'd0, busy}, 32'd0);
      check("mid done", {31'd0, done}, 32'd0);
      check("mid result", result, 32'd0);
      check_sels("mid", 3'b010, 3'b010);
      tick();
      check("mid held busy", {31'd0, busy}, 32'd0);
      rst_n = 1'b1;
      tick();
      start = 1'b1; dir = 1'b0; shamt = 5'd1; data_in = 32'h0000_0002;
      tick();
      start = 1'b0;
      check_sels("post c1", 3'b010, 3'b100);
      tick();
      check("post done", {31'd0, done}, 32'd1);
      check("post result", result, 32'h0000_0004);
      tick();
      check("post idle", {31'd0, busy}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
